// File: rtl/bsg_priority_serialize_one_hot_if.sv
// Request-vector intake (valid/ready) and grant-beat drain (valid/yumi)
// bundled for bsg_priority_serialize_one_hot.
interface bsg_priority_serialize_one_hot_if #(
  parameter int width_p = 32
);
  localparam int idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

  logic                    v_i;
  logic [width_p-1:0]      i;
  logic                    ready_o;
  logic                    v_o;
  logic [width_p-1:0]      o;
  logic [idx_width_lp-1:0] idx_o;
  logic                    last_o;
  logic                    yumi_i;

  // master: upstream producer plus downstream consumer seen from outside
  modport master (
    output v_i, i, yumi_i,
    input  ready_o, v_o, o, idx_o, last_o
  );

  // slave: the serializer itself
  modport slave (
    input  v_i, i, yumi_i,
    output ready_o, v_o, o, idx_o, last_o
  );
endinterface

// File: rtl/bsg_priority_serialize_one_hot.sv
// Accepts a request vector and hands it out one grant per beat, highest
// priority first, as a one-hot vector plus binary index.

// One-hot priority pick: isolates the lowest or highest set bit of req_i.
module bsg_priority_serialize_one_hot_pick #(
  parameter int width_p    = 32,
  parameter bit lo_to_hi_p = 1'b0
) (
  input  logic [width_p-1:0] req_i,
  output logic [width_p-1:0] o
);
  localparam logic [width_p-1:0] one_lp = width_p'(1);

  logic [width_p-1:0] req_rev;
  logic [width_p-1:0] sel_rev;

  // x & -x keeps only the lowest set bit; reversing turns it into the highest
  always_comb begin
    req_rev = '0;
    sel_rev = '0;
    o       = '0;
    if (lo_to_hi_p) begin
      o = req_i & (~req_i + one_lp);
    end else begin
      for (int k = 0; k < width_p; k++) req_rev[k] = req_i[width_p-1-k];
      sel_rev = req_rev & (~req_rev + one_lp);
      for (int k = 0; k < width_p; k++) o[k] = sel_rev[width_p-1-k];
    end
  end
endmodule

// One-hot to binary index; all-zero input encodes to 0.
module bsg_priority_serialize_one_hot_enc #(
  parameter int width_p      = 32,
  parameter int idx_width_lp = $clog2(width_p)
) (
  input  logic [width_p-1:0]      oh_i,
  output logic [idx_width_lp-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (oh_i[k]) idx_o = idx_o | idx_width_lp'(k);
    end
  end
endmodule

// state | meaning
// IDLE  | pending_r == 0, ready_o=1, waiting for a vector
// DRAIN | pending_r != 0, presenting one grant per beat until empty
module bsg_priority_serialize_one_hot #(
  parameter int width_p    = 32,
  parameter bit lo_to_hi_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_priority_serialize_one_hot_if.slave bus
);
  localparam int idx_width_lp = $clog2(width_p);

  logic [width_p-1:0]      pending_r;
  logic [width_p-1:0]      pending_n;
  logic [width_p-1:0]      grant;
  logic [idx_width_lp-1:0] grant_idx;
  logic                    accept;
  logic                    consume;

  bsg_priority_serialize_one_hot_pick #(
    .width_p    (width_p),
    .lo_to_hi_p (lo_to_hi_p)
  ) pick (
    .req_i (pending_r),
    .o     (grant)
  );

  bsg_priority_serialize_one_hot_enc #(
    .width_p      (width_p),
    .idx_width_lp (idx_width_lp)
  ) enc (
    .oh_i  (grant),
    .idx_o (grant_idx)
  );

  assign bus.ready_o = (pending_r == '0);
  assign bus.v_o     = |pending_r;
  assign bus.o       = grant;
  assign bus.idx_o   = grant_idx;
  assign bus.last_o  = bus.v_o & ((pending_r & ~grant) == '0);

  // accept and consume are mutually exclusive since ready_o implies !v_o
  assign accept  = bus.v_i & bus.ready_o;
  assign consume = bus.yumi_i & bus.v_o;

  always_comb begin
    pending_n = pending_r;
    if (accept) begin
      pending_n = bus.i;
    end else if (consume) begin
      pending_n = pending_r & ~grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_n;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(bus.yumi_i && !bus.v_o))
        else $error("yumi_i asserted with no beat presented");
      assert ($onehot0(grant))
        else $error("grant is not one-hot");
      assert ((grant & ~pending_r) == '0)
        else $error("grant selects a bit that is not pending");
    end
  end
`endif
endmodule

// File: tb/tb_bsg_priority_serialize_one_hot.sv
// Directed bench: table-driven vectors on the high-first instance, plus
// hand sequences for low-first order and randomized back-pressure.
module tb_bsg_priority_serialize_one_hot;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bsg_priority_serialize_one_hot_if #(.width_p(32)) bus_hi ();
  bsg_priority_serialize_one_hot_if #(.width_p(32)) bus_lo ();

  bsg_priority_serialize_one_hot #(.width_p(32), .lo_to_hi_p(1'b0)) dut_hi (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_hi.slave)
  );

  bsg_priority_serialize_one_hot #(.width_p(32), .lo_to_hi_p(1'b1)) dut_lo (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_lo.slave)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] i;
    logic        yumi;
    logic        ready;
    logic        v_o;
    logic [31:0] o;
    logic [4:0]  idx;
    logic        last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [31:0] i, logic yumi,
                              logic ready, logic v_o, logic [31:0] o,
                              logic [4:0] idx, logic last);
    vec_t r;
    r.rst = rst; r.v = v; r.i = i; r.yumi = yumi;
    r.ready = ready; r.v_o = v_o; r.o = o; r.idx = idx; r.last = last;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic check_hi(string tag, logic ready, logic v_o, logic [31:0] o,
                          logic [4:0] idx, logic last);
    check({tag, ".ready_o"}, 32'(bus_hi.ready_o), 32'(ready));
    check({tag, ".v_o"},     32'(bus_hi.v_o),     32'(v_o));
    check({tag, ".o"},       bus_hi.o,            o);
    check({tag, ".idx_o"},   32'(bus_hi.idx_o),   32'(idx));
    check({tag, ".last_o"},  32'(bus_hi.last_o),  32'(last));
  endtask

  task automatic check_lo(string tag, logic ready, logic v_o, logic [31:0] o,
                          logic [4:0] idx, logic last);
    check({tag, ".ready_o"}, 32'(bus_lo.ready_o), 32'(ready));
    check({tag, ".v_o"},     32'(bus_lo.v_o),     32'(v_o));
    check({tag, ".o"},       bus_lo.o,            o);
    check({tag, ".idx_o"},   32'(bus_lo.idx_o),   32'(idx));
    check({tag, ".last_o"},  32'(bus_lo.last_o),  32'(last));
  endtask

  initial begin
    int          beats;
    int          exp_idx;
    int          cyc;
    logic [31:0] prev_o;
    logic [4:0]  prev_idx;
    logic        stalled;

    bus_hi.v_i = 1'b0; bus_hi.i = '0; bus_hi.yumi_i = 1'b0;
    bus_lo.v_i = 1'b0; bus_lo.i = '0; bus_lo.yumi_i = 1'b0;

    // inputs applied during a row's cycle; expected outputs observed in that same cycle
    tbl.push_back(mk(0, 1, 32'h8000_0005, 0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h8000_0000, 5'd31, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h4,          5'd2,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h1,          5'd0,  1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'h0001_0000, 0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h0001_0000, 5'd16, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'h3,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 0, 1, 32'h2,          5'd1,  0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 0, 1, 32'h2,          5'd1,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h1,          5'd0,  1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'hF0,        0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h80,         5'd7,  0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 32'h40,         5'd6,  0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 1, 32'h3,         0, 1, 0, 32'h0,          5'd0,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h2,          5'd1,  0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h1,          5'd0,  1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          5'd0,  0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_hi($sformatf("idle%0d", c), 1, 0, 32'h0, 5'd0, 0);
    end
    check_lo("idle_lo", 1, 0, 32'h0, 5'd0, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      reset         = tbl[r].rst;
      bus_hi.v_i    = tbl[r].v;
      bus_hi.i      = tbl[r].i;
      bus_hi.yumi_i = tbl[r].yumi;
      check_hi($sformatf("row%0d", r), tbl[r].ready, tbl[r].v_o, tbl[r].o,
               tbl[r].idx, tbl[r].last);
    end
    @(negedge clk);
    reset = 1'b0; bus_hi.v_i = 1'b0; bus_hi.i = '0; bus_hi.yumi_i = 1'b0;

    // low-first order on the same vector
    bus_lo.v_i = 1'b1; bus_lo.i = 32'h8000_0005;
    @(negedge clk);
    bus_lo.v_i = 1'b0; bus_lo.i = '0; bus_lo.yumi_i = 1'b1;
    check_lo("lo_b0", 0, 1, 32'h1, 5'd0, 0);
    @(negedge clk);
    check_lo("lo_b1", 0, 1, 32'h4, 5'd2, 0);
    @(negedge clk);
    check_lo("lo_b2", 0, 1, 32'h8000_0000, 5'd31, 1);
    @(negedge clk);
    bus_lo.yumi_i = 1'b0;
    check_lo("lo_done", 1, 0, 32'h0, 5'd0, 0);

    // back-pressure drain of a full vector with random stalls and ignored v_i
    bus_hi.v_i = 1'b1; bus_hi.i = 32'hFFFF_FFFF;
    @(negedge clk);
    beats    = 0;
    exp_idx  = 31;
    stalled  = 1'b0;
    prev_o   = '0;
    prev_idx = '0;
    cyc      = 0;
    bus_hi.v_i = 1'b0;
    while (beats < 32 && cyc < 1000) begin
      check("bp.ready_o", 32'(bus_hi.ready_o), 32'h0);
      check("bp.v_o", 32'(bus_hi.v_o), 32'h1);
      check("bp.idx_o", 32'(bus_hi.idx_o), 32'(exp_idx));
      check("bp.o", bus_hi.o, 32'h1 << exp_idx);
      check("bp.last_o", 32'(bus_hi.last_o), 32'(exp_idx == 0));
      if (stalled) begin
        check("bp.stall_o", bus_hi.o, prev_o);
        check("bp.stall_idx", 32'(bus_hi.idx_o), 32'(prev_idx));
      end
      prev_o   = bus_hi.o;
      prev_idx = bus_hi.idx_o;
      bus_hi.yumi_i = 1'($urandom_range(0, 1));
      bus_hi.v_i    = 1'($urandom_range(0, 1));
      bus_hi.i      = $urandom() | 32'h1;
      stalled       = !bus_hi.yumi_i;
      if (bus_hi.yumi_i) begin
        beats++;
        exp_idx--;
      end
      cyc++;
      @(negedge clk);
    end
    check("bp.beats", 32'(beats), 32'd32);
    bus_hi.yumi_i = 1'b0; bus_hi.v_i = 1'b0; bus_hi.i = '0;
    check_hi("bp_done", 1, 0, 32'h0, 5'd0, 0);
    @(negedge clk);
    check_hi("bp_after", 1, 0, 32'h0, 5'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
